tinker_alu_arbiter: RTL and testbench

Sequencer and two-way arbiter that shares the single Tinker ALU/FPU datapath between two requesters, such as two issue ports or an issue port and a debug/microcode port. It accepts one operation at a time with a valid/ready handshake and picks the requester round-robin. It holds the operands stable on the ALU inputs for the operation's latency, then returns the registered result with the requester ID and destination tag. It sits between the issue logic and the ALU/FPU, which stays combinational.

---
 rtl/tinker_alu_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_tinker_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_alu_arbiter.sv
// Round-robin two-requester sequencer for the shared combinational Tinker ALU/FPU.
// Optional macro TINKER_ARB_DIV0_EN: integer divide-by-zero finishes early with rsp_err set.
module tinker_alu_arbiter #(
  parameter int LONG_LAT  = 4,
  parameter int SHORT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic        req_float0,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [4:0]  req_tag0,
  input  logic [3:0]  req_op1,
  input  logic        req_float1,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  input  logic [4:0]  req_tag1,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_is_float,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [4:0]  rsp_tag,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] LONG_LD  = 4'(LONG_LAT - 1);
  localparam logic [3:0] SHORT_LD = 4'(SHORT_LAT - 1);

  state_t      state_r;
  logic        rr_r;
  logic [3:0]  cnt_r;
  logic [63:0] alu_a_r;
  logic [63:0] alu_b_r;
  logic [3:0]  alu_op_r;
  logic        alu_is_float_r;
  logic        hold_id_r;
  logic [4:0]  hold_tag_r;
  logic        rsp_valid_r;
  logic        rsp_id_r;
  logic [4:0]  rsp_tag_r;
  logic [63:0] rsp_data_r;
  logic        busy_r;
`ifdef TINKER_ARB_DIV0_EN
  logic        div0_s;
  logic        div0_r;
  logic        rsp_err_r;
`endif

  logic        win_s;
  logic        grant_s;
  logic [3:0]  sel_op_s;
  logic        sel_float_s;
  logic [63:0] sel_a_s;
  logic [63:0] sel_b_s;
  logic [4:0]  sel_tag_s;
  logic        is_long_s;
  logic [3:0]  lat_ld_s;

  // Winner selection: a lone requester wins, otherwise the round-robin pointer decides.
  always_comb begin
    win_s = 1'b0;
    if (req_valid == 2'b11) begin
      win_s = rr_r;
    end else if (req_valid[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Grant decode; nothing is offered outside IDLE or while reset is held.
  always_comb begin
    req_ready = 2'b00;
    grant_s   = 1'b0;
    if ((state_r == IDLE) && !reset && (req_valid != 2'b00)) begin
      req_ready[win_s] = 1'b1;
      grant_s          = 1'b1;
    end else begin
      req_ready = 2'b00;
      grant_s   = 1'b0;
    end
  end

  // Payload mux from the winning requester and latency selection.
  always_comb begin
    sel_op_s    = win_s ? req_op1    : req_op0;
    sel_float_s = win_s ? req_float1 : req_float0;
    sel_a_s     = win_s ? req_a1     : req_a0;
    sel_b_s     = win_s ? req_b1     : req_b0;
    sel_tag_s   = win_s ? req_tag1   : req_tag0;
    is_long_s   = sel_float_s || (sel_op_s == OP_MUL) || (sel_op_s == OP_DIV);
`ifdef TINKER_ARB_DIV0_EN
    div0_s      = !sel_float_s && (sel_op_s == OP_DIV) && (sel_b_s == 64'd0);
    lat_ld_s    = (is_long_s && !div0_s) ? LONG_LD : SHORT_LD;
`else
    lat_ld_s    = is_long_s ? LONG_LD : SHORT_LD;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      rr_r           <= 1'b0;
      cnt_r          <= 4'd0;
      alu_a_r        <= 64'd0;
      alu_b_r        <= 64'd0;
      alu_op_r       <= 4'd0;
      alu_is_float_r <= 1'b0;
      hold_id_r      <= 1'b0;
      hold_tag_r     <= 5'd0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= 1'b0;
      rsp_tag_r      <= 5'd0;
      rsp_data_r     <= 64'd0;
      busy_r         <= 1'b0;
`ifdef TINKER_ARB_DIV0_EN
      div0_r         <= 1'b0;
      rsp_err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            alu_a_r        <= sel_a_s;
            alu_b_r        <= sel_b_s;
            alu_op_r       <= sel_op_s;
            alu_is_float_r <= sel_float_s;
            hold_id_r      <= win_s;
            hold_tag_r     <= sel_tag_s;
            cnt_r          <= lat_ld_s;
            rr_r           <= ~win_s;
            busy_r         <= 1'b1;
`ifdef TINKER_ARB_DIV0_EN
            div0_r         <= div0_s;
`endif
            state_r        <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= hold_id_r;
            rsp_tag_r   <= hold_tag_r;
`ifdef TINKER_ARB_DIV0_EN
            rsp_data_r  <= div0_r ? 64'd0 : alu_result;
            rsp_err_r   <= div0_r;
`else
            rsp_data_r  <= alu_result;
`endif
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign alu_is_float = alu_is_float_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_id       = rsp_id_r;
  assign rsp_tag      = rsp_tag_r;
  assign rsp_data     = rsp_data_r;
  assign busy         = busy_r;
`ifdef TINKER_ARB_DIV0_EN
  assign rsp_err      = rsp_err_r;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tinker_alu_arbiter.sv
// Scoreboard bench for tinker_alu_arbiter with a behavioural ALU/FPU model.
module tb_tinker_alu_arbiter;
  localparam int LONG_LAT  = 4;
  localparam int SHORT_LAT = 1;
`ifdef TINKER_ARB_DIV0_EN
  localparam logic DIV0_ERR = 1'b1;
  localparam int   DIV0_LAT = SHORT_LAT;
`else
  localparam logic DIV0_ERR = 1'b0;
  localparam int   DIV0_LAT = LONG_LAT;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0 = 4'd0, req_op1 = 4'd0;
  logic        req_float0 = 1'b0, req_float1 = 1'b0;
  logic [63:0] req_a0 = 64'd0, req_b0 = 64'd0, req_a1 = 64'd0, req_b1 = 64'd0;
  logic [4:0]  req_tag0 = 5'd0, req_tag1 = 5'd0;
  logic [63:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]  alu_op;
  logic        alu_is_float, rsp_valid, rsp_id, rsp_err, busy;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_tag;

  tinker_alu_arbiter #(.LONG_LAT(LONG_LAT), .SHORT_LAT(SHORT_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_float0(req_float0), .req_a0(req_a0), .req_b0(req_b0), .req_tag0(req_tag0),
    .req_op1(req_op1), .req_float1(req_float1), .req_a1(req_a1), .req_b1(req_b1), .req_tag1(req_tag1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_float(alu_is_float), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU/FPU stand-in.
  always_comb begin
    alu_result = 64'd0;
    if (alu_is_float) begin
      case (alu_op)
        4'd0: alu_result = $realtobits($bitstoreal(alu_a) + $bitstoreal(alu_b));
        4'd1: alu_result = $realtobits($bitstoreal(alu_a) - $bitstoreal(alu_b));
        4'd2: alu_result = $realtobits($bitstoreal(alu_a) * $bitstoreal(alu_b));
        default: alu_result = 64'd0;
      endcase
    end else begin
      case (alu_op)
        4'd0: alu_result = alu_a + alu_b;
        4'd1: alu_result = alu_a - alu_b;
        4'd2: alu_result = alu_a * alu_b;
        4'd3: alu_result = (alu_b == 64'd0) ? 64'd0 : alu_a / alu_b;
        4'd4: alu_result = alu_a >> alu_b[5:0];
        4'd5: alu_result = alu_a << alu_b[5:0];
        4'd6: alu_result = alu_a & alu_b;
        4'd7: alu_result = alu_a | alu_b;
        4'd8: alu_result = alu_a ^ alu_b;
        4'd9: alu_result = ~alu_a;
        default: alu_result = 64'd0;
      endcase
    end
  end

  typedef struct {
    logic        id;
    logic [4:0]  tag;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] exp_data [2];
  logic        exp_err [2];
  int          exp_lat [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: records accepts, checks operand hold, latency, stall stability and responses.
  exp_t        e, p;
  logic        w;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_id = 1'b0, prev_err = 1'b0;
  logic [4:0]  prev_tag = 5'd0;
  logic [63:0] prev_data = 64'd0, hold_a = 64'd0, hold_b = 64'd0;
  logic [3:0]  hold_op = 4'd0;
  logic        hold_fl = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if ((req_valid & req_ready) != 2'b00) begin
        w         = req_ready[1];
        e.id      = w;
        e.tag     = w ? req_tag1 : req_tag0;
        e.data    = exp_data[w];
        e.err     = exp_err[w];
        e.lat     = exp_lat[w];
        e.acc_cyc = cyc;
        sb.push_back(e);
        hold_a  = w ? req_a1 : req_a0;
        hold_b  = w ? req_b1 : req_b0;
        hold_op = w ? req_op1 : req_op0;
        hold_fl = w ? req_float1 : req_float0;
      end
      if (busy && !rsp_valid) begin
        chk("exec_alu_a", alu_a, hold_a);
        chk("exec_alu_b", alu_b, hold_b);
        chk("exec_alu_op", 64'(alu_op), 64'(hold_op));
        chk("exec_alu_float", 64'(alu_is_float), 64'(hold_fl));
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat + 1));
      end
      if (rsp_valid && prev_valid && !prev_hs) begin
        chk("stall_data", rsp_data, prev_data);
        chk("stall_tag", 64'(rsp_tag), 64'(prev_tag));
        chk("stall_id", 64'(rsp_id), 64'(prev_id));
        chk("stall_err", 64'(rsp_err), 64'(prev_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_no_expect", 64'd1, 64'd0);
        end else begin
          p = sb.pop_front();
          chk("rsp_data", rsp_data, p.data);
          chk("rsp_id", 64'(rsp_id), 64'(p.id));
          chk("rsp_tag", 64'(rsp_tag), 64'(p.tag));
          chk("rsp_err", 64'(rsp_err), 64'(p.err));
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_data  = rsp_data;
      prev_tag   = rsp_tag;
      prev_id    = rsp_id;
      prev_err   = rsp_err;
    end
  end

  task automatic present(input int i, input logic [3:0] op, input logic fl, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input logic [63:0] ed,
                         input logic ee, input int lat);
    if (i == 0) begin
      req_op0 = op; req_float0 = fl; req_a0 = a; req_b0 = b; req_tag0 = tag;
    end else begin
      req_op1 = op; req_float1 = fl; req_a1 = a; req_b1 = b; req_tag1 = tag;
    end
    exp_data[i]  = ed;
    exp_err[i]   = ee;
    exp_lat[i]   = lat;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(output int who, output int at_cyc);
    who    = -1;
    at_cyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        who    = req_ready[1] ? 1 : 0;
        at_cyc = cyc;
        break;
      end
    end
    if (who < 0) chk("grant_timeout", 64'd1, 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sb.size() == 0) break;
    end
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
    chk({tag, "_alu_b"}, alu_b, 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_alu_float"}, 64'(alu_is_float), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  logic [63:0] a0_t [6] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
  logic [63:0] b0_t [6] = '{64'd100, 64'd200, 64'd300, 64'd400, 64'd500, 64'd600};
  logic [63:0] e0_t [6] = '{64'd101, 64'd202, 64'd303, 64'd404, 64'd505, 64'd606};
  logic [63:0] a1_t [6] = '{64'd1000, 64'd2000, 64'd3000, 64'd4000, 64'd5000, 64'd6000};
  logic [63:0] e1_t [6] = '{64'd1007, 64'd2007, 64'd3007, 64'd4007, 64'd5007, 64'd6007};

  initial begin
    int who, gc, prev_gc, n;
    int idx [2];

    // Reset values and no grant while reset is high.
    repeat (3) @(posedge clk);
    #2 req_valid = 2'b01;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #2;
    req_valid = 2'b00;
    reset = 1'b0;

    // Single ADD from requester 0.
    present(0, 4'd0, 1'b0, 64'd5, 64'd7, 5'd3, 64'd12, 1'b0, SHORT_LAT);
    wait_grant(who, gc);
    chk("t1_winner", 64'(who), 64'd0);
    req_valid[0] = 1'b0;
    wait_idle();

    // Contention: both requesters always valid, six ADDs each.
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    idx[0] = 0;
    idx[1] = 0;
    prev_gc = 0;
    present(0, 4'd0, 1'b0, a0_t[0], b0_t[0], 5'd0, e0_t[0], 1'b0, SHORT_LAT);
    present(1, 4'd0, 1'b0, a1_t[0], 64'd7, 5'd16, e1_t[0], 1'b0, SHORT_LAT);
    for (int g = 0; g < 12; g++) begin
      wait_grant(who, gc);
      if (who < 0) break;
      chk("rr_order", 64'(who), 64'(g % 2));
      if (g > 0) chk("grant_gap", 64'(gc - prev_gc), 64'(SHORT_LAT + 2));
      prev_gc = gc;
      idx[who]++;
      if (idx[who] < 6) begin
        if (who == 0)
          present(0, 4'd0, 1'b0, a0_t[idx[0]], b0_t[idx[0]], 5'(idx[0]), e0_t[idx[0]], 1'b0, SHORT_LAT);
        else
          present(1, 4'd0, 1'b0, a1_t[idx[1]], 64'd7, 5'(16 + idx[1]), e1_t[idx[1]], 1'b0, SHORT_LAT);
      end else begin
        req_valid[who] = 1'b0;
      end
    end
    req_valid = 2'b00;
    wait_idle();

    // Float MUL 2.0 * 3.0 from requester 1.
    present(1, 4'd2, 1'b1, 64'h4000000000000000, 64'h4008000000000000, 5'd7,
            64'h4018000000000000, 1'b0, LONG_LAT);
    wait_grant(who, gc);
    chk("fmul_winner", 64'(who), 64'd1);
    req_valid[1] = 1'b0;
    wait_idle();

    // Unknown op 12 passes through as a short op returning 0.
    present(0, 4'd12, 1'b0, 64'd5, 64'd5, 5'd4, 64'd0, 1'b0, SHORT_LAT);
    wait_grant(who, gc);
    req_valid[0] = 1'b0;
    wait_idle();

    // Response backpressure for 10 cycles.
    rsp_ready = 1'b0;
    present(0, 4'd1, 1'b0, 64'd50, 64'd8, 5'd9, 64'd42, 1'b0, SHORT_LAT);
    wait_grant(who, gc);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("stall_rsp_seen", 64'(rsp_valid), 64'd1);
    @(posedge clk); #2;
    present(1, 4'd8, 1'b0, 64'hF0F0, 64'h0FF0, 5'd10, 64'hFF00, 1'b0, SHORT_LAT);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if ((req_valid & req_ready) != 2'b00) break;
    end
    chk("regrant_delay", 64'(n), 64'd2);
    @(posedge clk); #2;
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the second EXEC cycle of a DIV aborts it and clears rr.
    present(0, 4'd3, 1'b0, 64'd20, 64'd4, 5'd12, 64'd5, 1'b0, LONG_LAT);
    wait_grant(who, gc);
    req_valid[0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    chk_reset_outputs("abort");
    sb.delete();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #2;
    present(0, 4'd0, 1'b0, 64'd3, 64'd4, 5'd1, 64'd7, 1'b0, SHORT_LAT);
    present(1, 4'd0, 1'b0, 64'd8, 64'd8, 5'd2, 64'd16, 1'b0, SHORT_LAT);
    wait_grant(who, gc);
    chk("rr_after_reset", 64'(who), 64'd0);
    req_valid[0] = 1'b0;
    wait_grant(who, gc);
    chk("rr_second", 64'(who), 64'd1);
    req_valid[1] = 1'b0;
    wait_idle();

    // Integer divide by zero.
    present(0, 4'd3, 1'b0, 64'd9, 64'd0, 5'd13, 64'd0, DIV0_ERR, DIV0_LAT);
    wait_grant(who, gc);
    req_valid[0] = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
